// File: rtl/adam_pause_seq.sv
// adam_pause_seq: pauses targets in ascending order, resumes them descending.
// Define ADAM_PAUSE_SEQ_TIMEOUT_EN to add a sticky per-target watchdog on err.
module adam_pause_seq #(
  parameter int NO_TARGETS = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pause_req,
  output logic                  pause_ack,
  output logic [NO_TARGETS-1:0] tgt_req,
  input  logic [NO_TARGETS-1:0] tgt_ack,
  output logic                  err
);

  localparam int IW = (NO_TARGETS > 1) ? $clog2(NO_TARGETS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NO_TARGETS - 1);

  typedef enum logic [1:0] {
    RUN,
    PAUSING,
    PAUSED,
    RESUMING
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [IW-1:0]           idx_inc, idx_dec;
  logic                    ack_q, ack_d;
  logic [NO_TARGETS-1:0]   req_q, req_d;

  assign idx_inc = idx_q + 1'b1;
  assign idx_dec = idx_q - 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ack_d   = ack_q;
    req_d   = req_q;
    unique case (state_q)
      RUN: begin
        if (pause_req) begin
          idx_d    = '0;
          req_d[0] = 1'b1;
          state_d  = PAUSING;
        end
      end
      PAUSING: begin
        if (tgt_ack[idx_q]) begin
          if (idx_q == LAST) begin
            ack_d   = 1'b1;
            state_d = PAUSED;
          end else begin
            idx_d          = idx_inc;
            req_d[idx_inc] = 1'b1;
          end
        end
      end
      PAUSED: begin
        // A request dropped early is only honoured once fully paused
        if (!pause_req) begin
          req_d[LAST] = 1'b0;
          idx_d       = LAST;
          state_d     = RESUMING;
        end
      end
      RESUMING: begin
        if (!tgt_ack[idx_q]) begin
          if (idx_q == '0) begin
            ack_d   = 1'b0;
            state_d = RUN;
          end else begin
            idx_d          = idx_dec;
            req_d[idx_dec] = 1'b0;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
      req_q   <= req_d;
    end
  end

  assign pause_ack = ack_q;
  assign tgt_req   = req_q;

`ifdef ADAM_PAUSE_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          waiting;

  assign waiting = (state_q == PAUSING) || (state_q == RESUMING);

  // Restart the wait on every step of the sequence; saturate at the limit
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if ((state_d != state_q) || (idx_d != idx_q)) begin
      cnt_d = '0;
    end else if (waiting && (cnt_q != TMAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cnt_d == TMAX) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign err = 1'b0;
`endif

endmodule

// File: doc/adam_pause_seq.md
# adam_pause_seq

Hierarchical pause requester. It answers an upstream pause handshake on its slave side and drives NO_TARGETS downstream pause handshakes on its master side, such as adam_axil_pause bridges. Targets are paused one at a time in ascending index order and resumed in descending order. Upstream ack is given only once every target has acknowledged, so several pausable blocks can sit behind one pause point in the power/clock-gating tree.

## Interface
- NO_TARGETS, default 2: number of downstream pause handshakes; must be ≥1.
- TIMEOUT, default 1024: watchdog limit in cycles, used only with ADAM_PAUSE_SEQ_TIMEOUT_EN; must be ≥1.

Ports:
- seq.clk  in  1  clock, rising edge.
- seq.rst  in  1  reset, asynchronous, active-high.
- pause.req  in  1  upstream pause request.
- pause.ack  out  1  upstream pause acknowledge.
- tgt_req  out  NO_TARGETS  per-target pause request.
- tgt_ack  in  NO_TARGETS  per-target pause acknowledge.
- err  out  1  sticky watchdog error.

## Operation
Pause protocol is 4-phase on both sides:
- Requester raises req; responder raises ack when paused.
- Requester drops req; responder drops ack when resumed.
- req changes only when ack == req.

State machine states: RUN, PAUSING, PAUSED, RESUMING. Index register idx has width max(1, $clog2(NO_TARGETS)).

Transitions:
- RUN: pause.ack=0, all tgt_req=0. On pause.req=1: idx←0, tgt_req[0]←1, go to PAUSING.
- PAUSING: wait for tgt_ack[idx]=1.
  - If idx=NO_TARGETS-1: pause.ack←1, go to PAUSED.
  - Else: idx←idx+1 and raise that target's req on the same edge.
- PAUSED: pause.ack=1, all tgt_req=1. On pause.req=0: tgt_req[NO_TARGETS-1]←0, idx←NO_TARGETS-1, go to RESUMING.
- RESUMING: wait for tgt_ack[idx]=0.
  - If idx=0: pause.ack←0, go to RUN.
  - Else: idx←idx-1 and drop that target's req on the same edge.

Rules:
- At most one tgt_req edge per cycle.
- tgt_req[j] for j>idx stays 0 while pausing; for j<idx stays 1 while resuming.
- Upstream req dropped before ack (protocol violation): the pause sequence still completes to PAUSED, then req=0 is acted on normally. No abort path.
- tgt_ack of targets not currently indexed is ignored.
- NO_TARGETS=1: PAUSING/RESUMING each wait on target 0 only.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values: pause.ack=0, tgt_req=0, err=0, state=RUN, idx=0, watchdog counter=0. Assertion of seq.rst mid-sequence returns all of these immediately, asynchronously.
- Upstream req sampled at edge E: tgt_req[0] high after E.
- tgt_ack[i] sampled high at edge F: tgt_req[i+1] (or pause.ack) high after F.
- With targets echoing req through one flop, pause.ack rises 2·NO_TARGETS edges after E. Resume latency is symmetric.
- Responsiveness:
  - Zero-latency (combinational) target acks: one edge per target.
  - pause.req already 1 on the cycle after entering RUN: next pause starts on that edge.

## Configuration
ADAM_PAUSE_SEQ_TIMEOUT_EN.

Defined:
- A counter clears on every idx change and on every state entry, and increments each cycle spent in PAUSING/RESUMING.
- When it reaches TIMEOUT, err←1, sticky until seq.rst.
- The FSM keeps waiting; no target is skipped.
- The counter saturates at TIMEOUT.

Undefined:
- No counter is present; err is tied 0.
- TIMEOUT is unused.

## Test plan
- Reset and idle: hold seq.rst 5 cycles with pause.req=0 → pause.ack=0, tgt_req=0, err=0. Asserting rst mid-PAUSING with tgt_req=2'b01 clears all outputs in the same cycle.
- Ordered pause: NO_TARGETS=3, 1-flop echo targets; raise pause.req → tgt_req goes 001, 011, 111, each 2 edges apart. pause.ack rises 6 edges after the sampling edge.
- Ordered resume: from PAUSED drop pause.req → tgt_req goes 111, 011, 001, 000 in that order. pause.ack falls after tgt_ack[0] is sampled low.
- Slow/random targets: targets ack after random 0–100 cycles, 100 pause/resume rounds, upstream obeys 4-phase → never more than one tgt_req edge per cycle, ack never precedes all tgt_ack, no hang.
- Early upstream drop: drop pause.req while idx=1 of 3 → sequence still reaches tgt_req=111 and pause.ack=1, then resumes fully to 000/0.
- Watchdog (macro defined, TIMEOUT=16): tgt[1] never acks → err rises exactly 16 cycles after tgt_req[1] rose and stays 1. A later tgt_ack[1] completes the pause. Macro undefined: err stays 0.
